hamming_encode_arbiter: RTL and testbench

Shares one (7,4) Hamming encoder among NUM_REQ requesters. Each requester presents a 4-bit message with a valid/ready handshake. A round-robin arbiter picks one request per cycle. The winner is encoded and captured in a single output register that carries the requester ID and honours downstream backpressure. The block sits between the message producers and the channel/storage write path.

---
 rtl/hamming_pkg.sv | 22 ++
 rtl/hamming_encode_arbiter_if.sv | 31 +++
 rtl/hamming74_encode_core.sv | 20 ++
 rtl/hamming_encode_arbiter.sv | 122 ++++++++++++
 tb/tb_hamming_encode_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/hamming_pkg.sv
// Shared constants and types for the shared (7,4) Hamming encoder with
// round-robin arbitration.
package hamming_pkg;

  localparam int unsigned MSG_BITS  = 4;
  localparam int unsigned CODE_BITS = 7;

  // Codeword bit positions
  localparam int unsigned DATA0 = 0;
  localparam int unsigned DATA1 = 1;
  localparam int unsigned DATA2 = 2;
  localparam int unsigned PAR0  = 3;
  localparam int unsigned DATA3 = 4;
  localparam int unsigned PAR1  = 5;
  localparam int unsigned PAR2  = 6;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/hamming_encode_arbiter_if.sv
// Requester and downstream handshake bundle for hamming_encode_arbiter.
interface hamming_encode_arbiter_if
  import hamming_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_BITS    = 2,
  parameter int unsigned COUNT_BITS = 16
);

  logic [NUM_REQ-1:0]          REQ_VALID;
  logic [MSG_BITS*NUM_REQ-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]          REQ_READY;
  logic                        OUT_VALID;
  logic                        OUT_READY;
  logic [CODE_BITS-1:0]        OUT_DATA;
  logic [ID_BITS-1:0]          OUT_ID;
  logic [COUNT_BITS-1:0]       ENC_COUNT;

  // Arbiter side
  modport slave (
    input  REQ_VALID, REQ_DATA, OUT_READY,
    output REQ_READY, OUT_VALID, OUT_DATA, OUT_ID, ENC_COUNT
  );

  // Producer / consumer side
  modport master (
    output REQ_VALID, REQ_DATA, OUT_READY,
    input  REQ_READY, OUT_VALID, OUT_DATA, OUT_ID, ENC_COUNT
  );

endinterface

// File: rtl/hamming74_encode_core.sv
// Combinational (7,4) Hamming encoder: data bits at 0,1,2,4, parity at 3,5,6.
module hamming74_encode_core
  import hamming_pkg::*;
(
  input  logic [MSG_BITS-1:0]  msg,
  output logic [CODE_BITS-1:0] code
);

  always_comb begin
    code        = '0;
    code[DATA0] = msg[0];
    code[DATA1] = msg[1];
    code[DATA2] = msg[2];
    code[DATA3] = msg[3];
    code[PAR0]  = msg[3] ^ msg[2] ^ msg[0];
    code[PAR1]  = msg[3] ^ msg[1] ^ msg[0];
    code[PAR2]  = msg[2] ^ msg[1] ^ msg[0];
  end

endmodule

// File: rtl/hamming_encode_arbiter.sv
// Round-robin arbiter feeding one shared Hamming encoder into a single
// output register that carries the winning requester ID.
module hamming_encode_arbiter
  import hamming_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_BITS    = 2,
  parameter int unsigned COUNT_BITS = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  hamming_encode_arbiter_if.slave  bus
);

  if (ID_BITS != $clog2(NUM_REQ)) begin : g_bad_id_bits
    $error("ID_BITS must equal clog2(NUM_REQ)");
  end

  out_state_e            state;
  logic [CODE_BITS-1:0]  data_q;
  logic [ID_BITS-1:0]    id_q;
  logic [COUNT_BITS-1:0] count_q;
  logic [ID_BITS-1:0]    ptr;

  logic                  out_valid;
  logic                  load_en;
  logic                  drain;
  logic                  hi_any;
  logic                  lo_any;
  logic [ID_BITS-1:0]    hi_idx;
  logic [ID_BITS-1:0]    lo_idx;
  logic [MSG_BITS-1:0]   hi_msg;
  logic [MSG_BITS-1:0]   lo_msg;
  logic                  grant_found;
  logic [ID_BITS-1:0]    grant_idx;
  logic [MSG_BITS-1:0]   sel_msg;
  logic [NUM_REQ-1:0]    grant_vec;
  logic [CODE_BITS-1:0]  enc_code;
  logic [ID_BITS-1:0]    ptr_next;

  assign out_valid = (state == FULL);
  assign load_en   = !out_valid || bus.OUT_READY;
  assign drain     = out_valid && bus.OUT_READY;

  // Lowest valid index at/above the pointer wins; otherwise wrap to lowest valid.
  always_comb begin
    hi_any    = 1'b0;
    lo_any    = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    hi_msg    = '0;
    lo_msg    = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (bus.REQ_VALID[i]) begin
        lo_any = 1'b1;
        lo_idx = ID_BITS'(i);
        lo_msg = bus.REQ_DATA[i*MSG_BITS +: MSG_BITS];
        if (ID_BITS'(i) >= ptr) begin
          hi_any = 1'b1;
          hi_idx = ID_BITS'(i);
          hi_msg = bus.REQ_DATA[i*MSG_BITS +: MSG_BITS];
        end
      end
    end
    grant_found = (hi_any || lo_any) && load_en && !RST;
    grant_idx   = hi_any ? hi_idx : lo_idx;
    sel_msg     = hi_any ? hi_msg : lo_msg;
    grant_vec   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      grant_vec[i] = grant_found && (grant_idx == ID_BITS'(i));
    end
  end

  hamming74_encode_core u_enc (
    .msg  (sel_msg),
    .code (enc_code)
  );

  assign ptr_next = (grant_idx == ID_BITS'(NUM_REQ - 1)) ? '0
                                                         : grant_idx + ID_BITS'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      count_q <= '0;
      ptr     <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (grant_found) begin
            state  <= FULL;
            data_q <= enc_code;
            id_q   <= grant_idx;
            ptr    <= ptr_next;
          end
        end
        FULL: begin
          if (grant_found) begin
            data_q <= enc_code;
            id_q   <= grant_idx;
            ptr    <= ptr_next;
          end else if (bus.OUT_READY) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
      if (drain) begin
        count_q <= count_q + COUNT_BITS'(1);
      end
    end
  end

  assign bus.REQ_READY = grant_vec;
  assign bus.OUT_VALID = out_valid;
  assign bus.OUT_DATA  = data_q;
  assign bus.OUT_ID    = id_q;
  assign bus.ENC_COUNT = count_q;

endmodule

// File: tb/tb_hamming_encode_arbiter.sv
// Bench for hamming_encode_arbiter: behavioural model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_hamming_encode_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hamming_encode_arbiter_if #(.NUM_REQ(4), .ID_BITS(2), .COUNT_BITS(16)) bus ();

  hamming_encode_arbiter #(.NUM_REQ(4), .ID_BITS(2), .COUNT_BITS(16)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_enc(input logic [3:0] d);
    logic [6:0] c;
    c    = '0;
    c[0] = d[0];
    c[1] = d[1];
    c[2] = d[2];
    c[4] = d[3];
    c[3] = ^(d & 4'b1101);
    c[5] = ^(d & 4'b1011);
    c[6] = ^(d & 4'b0111);
    return c;
  endfunction

  // Model of the output register, counter and round-robin pointer
  logic        m_valid = 1'b0;
  logic [6:0]  m_data  = '0;
  logic [1:0]  m_id    = '0;
  logic [15:0] m_count = '0;
  int          m_ptr   = 0;

  always @(negedge clk) begin : compare
    int         g;
    logic [3:0] exp_rdy;
    logic [3:0] msg;
    g = -1;
    if (!rst && (!m_valid || bus.OUT_READY)) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && bus.REQ_VALID[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    chk("model_req_ready", 32'(bus.REQ_READY), 32'(exp_rdy));
    chk("model_out_valid", 32'(bus.OUT_VALID), 32'(m_valid));
    chk("model_out_data", 32'(bus.OUT_DATA), 32'(m_data));
    chk("model_out_id", 32'(bus.OUT_ID), 32'(m_id));
    chk("model_enc_count", 32'(bus.ENC_COUNT), 32'(m_count));
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_id    = '0;
      m_count = '0;
      m_ptr   = 0;
    end else begin
      if (m_valid && bus.OUT_READY) m_count = m_count + 16'd1;
      if (g >= 0) begin
        msg     = bus.REQ_DATA[g*4 +: 4];
        m_valid = 1'b1;
        m_data  = ref_enc(msg);
        m_id    = 2'(g);
        m_ptr   = (g + 1) % N;
      end else if (m_valid && bus.OUT_READY) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] code;
    bus.REQ_VALID = 4'b1111;
    bus.REQ_DATA  = 16'h5A5A;
    bus.OUT_READY = 1'b0;
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("reset_req_ready", 32'(bus.REQ_READY), 32'h0);
    chk("reset_out_valid", 32'(bus.OUT_VALID), 32'h0);
    chk("reset_enc_count", 32'(bus.ENC_COUNT), 32'h0);
    step();
    rst = 1'b0;

    // Single requester 0, message 1011
    bus.REQ_VALID = 4'b0001;
    bus.REQ_DATA  = 16'h000B;
    bus.OUT_READY = 1'b1;
    @(negedge clk);
    chk("t1_grant", 32'(bus.REQ_READY), 32'h1);
    step();
    bus.REQ_VALID = 4'b0000;
    @(negedge clk);
    chk("t1_valid", 32'(bus.OUT_VALID), 32'h1);
    chk("t1_data", 32'(bus.OUT_DATA), 32'(7'b0110011));
    chk("t1_id", 32'(bus.OUT_ID), 32'h0);
    chk("t1_count_before", 32'(bus.ENC_COUNT), 32'h0);
    step();
    @(negedge clk);
    chk("t1_count_after", 32'(bus.ENC_COUNT), 32'h1);
    chk("t1_drained", 32'(bus.OUT_VALID), 32'h0);
    step();

    // Codeword sweep on requester 2
    for (int m = 0; m < 16; m++) begin
      bus.REQ_VALID = 4'b0100;
      bus.REQ_DATA  = 16'(m) << 8;
      step();
      bus.REQ_VALID = 4'b0000;
      @(negedge clk);
      code = bus.OUT_DATA;
      chk("t2_id", 32'(bus.OUT_ID), 32'h2);
      if (m == 0)  chk("t2_code_0000", 32'(code), 32'h00);
      if (m == 15) chk("t2_code_1111", 32'(code), 32'h7F);
      if (m == 1)  chk("t2_code_0001", 32'(code), 32'(7'b1101001));
      step();
    end

    // All requesters valid: strict rotation, one word per cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.REQ_VALID = 4'b1111;
    bus.REQ_DATA  = 16'h4321;
    bus.OUT_READY = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t3_grant", 32'(bus.REQ_READY), 32'(1 << (k % 4)));
      chk("t3_throughput", 32'(bus.OUT_VALID), 32'(k > 0));
      step();
    end
    bus.REQ_VALID = 4'b0000;
    step();
    @(negedge clk);
    chk("t3_count", 32'(bus.ENC_COUNT), 32'd8);
    step();

    // Backpressure: requester 0 (message 0001) held for 5 cycles
    bus.REQ_VALID = 4'b1111;
    bus.OUT_READY = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t4_hold_data", 32'(bus.OUT_DATA), 32'h69);
      chk("t4_hold_id", 32'(bus.OUT_ID), 32'h0);
      chk("t4_no_grant", 32'(bus.REQ_READY), 32'h0);
      step();
    end
    bus.OUT_READY = 1'b1;
    @(negedge clk);
    chk("t4_release_grant", 32'(bus.REQ_READY), 32'h2);
    step();
    bus.REQ_VALID = 4'b0000;
    step();

    // Pointer wrap: move pointer to 2, then only requesters 3 and 1 valid
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.REQ_VALID = 4'b0010;
    bus.OUT_READY = 1'b1;
    step();
    bus.REQ_VALID = 4'b1010;
    @(negedge clk);
    chk("t5_first", 32'(bus.REQ_READY), 32'h8);
    step();
    @(negedge clk);
    chk("t5_second", 32'(bus.REQ_READY), 32'h2);
    step();
    @(negedge clk);
    chk("t5_third", 32'(bus.REQ_READY), 32'h8);
    step();
    bus.REQ_VALID = 4'b0000;
    step();

    // Reset while a word is held under backpressure
    bus.REQ_VALID = 4'b0001;
    bus.OUT_READY = 1'b0;
    step();
    bus.REQ_VALID = 4'b0000;
    @(negedge clk);
    chk("t6_held", 32'(bus.OUT_VALID), 32'h1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.REQ_VALID = 4'b0110;
    @(negedge clk);
    chk("t6_valid_cleared", 32'(bus.OUT_VALID), 32'h0);
    chk("t6_count_cleared", 32'(bus.ENC_COUNT), 32'h0);
    chk("t6_first_grant", 32'(bus.REQ_READY), 32'h2);
    step();
    bus.REQ_VALID = 4'b0000;
    bus.OUT_READY = 1'b1;
    step();

    // Random traffic with occasional reset
    for (int c = 0; c < 3000; c++) begin
      bus.REQ_VALID = 4'($urandom);
      bus.REQ_DATA  = 16'($urandom);
      bus.OUT_READY = ($urandom_range(3) != 0);
      rst           = ($urandom_range(63) == 0);
      step();
    end
    rst = 1'b0;
    bus.REQ_VALID = 4'b0000;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
